// File: rtl/jpeg_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_dec_pkg
// Description : Shared types and byte constants for the JPEG scan decoder front end.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_dec_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        GOT_FF = 2'd1,
        MARKER = 2'd2
    } dec_state_t;

    localparam logic [7:0] BYTE_FF    = 8'hFF;
    localparam logic [7:0] BYTE_STUFF = 8'h00;
    localparam logic [7:0] RST0       = 8'hD0;
    localparam logic [7:0] RST1       = 8'hD1;
    localparam logic [7:0] RST2       = 8'hD2;
    localparam logic [7:0] RST3       = 8'hD3;
    localparam logic [7:0] RST4       = 8'hD4;
    localparam logic [7:0] RST5       = 8'hD5;
    localparam logic [7:0] RST6       = 8'hD6;
    localparam logic [7:0] RST7       = 8'hD7;
    localparam logic [7:0] EOI        = 8'hD9;

    localparam int DEF_BUF_W = 32;
    localparam int DEF_WIN_W = 16;
    localparam int DEF_CNT_W = 6;

endpackage
`default_nettype wire

// File: rtl/jpeg_bitbuf.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_bitbuf
// Description : MSB-aligned bit buffer with byte push, variable consume and
//               1-padded peek window.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_bitbuf
    import jpeg_dec_pkg::*;
#(
    parameter int BUF_W = DEF_BUF_W,
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [7:0]       push_byte,
    input  logic             cons_valid,
    input  logic [4:0]       cons_len,
    output logic [WIN_W-1:0] win,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_byte_bits = CNT_W'(8);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [CNT_W-1:0] w_len_ext;
    logic             w_cons_ok;
    logic             w_cons_bad;
    logic [BUF_W-1:0] w_shifted;
    logic [CNT_W-1:0] w_cnt_mid;
    logic [BUF_W-1:0] w_byte_pos;

    // Bits below count are always zero, so a push can simply OR the byte in.
    always_comb begin
        w_len_ext  = CNT_W'(cons_len);
        w_cons_ok  = cons_valid && (w_len_ext <= r_count);
        w_cons_bad = cons_valid && !w_cons_ok;
        w_shifted  = w_cons_ok ? (r_buf << cons_len) : r_buf;
        w_cnt_mid  = w_cons_ok ? (r_count - w_len_ext) : r_count;
        w_byte_pos = {push_byte, {(BUF_W-8){1'b0}}} >> w_cnt_mid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_buf   <= '0;
            r_count <= '0;
        end else begin
            r_buf   <= push ? (w_shifted | w_byte_pos) : w_shifted;
            r_count <= push ? (w_cnt_mid + c_byte_bits) : w_cnt_mid;
            r_err   <= r_err | w_cons_bad;
        end
    end

    for (genvar i = 0; i < WIN_W; i++) begin : g_pad
        assign win[WIN_W-1-i] = (r_count > CNT_W'(i)) ? r_buf[BUF_W-1-i] : 1'b1;
    end

    assign count = r_count;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/jpeg_bitstream_reader.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_bitstream_reader
// Description : Scan-byte unstuffer and marker detector feeding an MSB-first
//               bit window to the Huffman decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_bitstream_reader
    import jpeg_dec_pkg::*;
#(
    parameter int BUF_W = DEF_BUF_W,
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIN_W-1:0] win,
    output logic [CNT_W-1:0] bits_avail,
    input  logic             cons_valid,
    input  logic [4:0]       cons_len,
    output logic             marker_valid,
    output logic [7:0]       marker_code,
    input  logic             marker_ack,
    output logic             err
);

    dec_state_t       r_state;
    logic             r_marker_valid;
    logic [7:0]       r_marker_code;

    logic [CNT_W-1:0] w_count;
    logic             w_accept;
    logic             w_ack;
    logic             w_push;
    logic [7:0]       w_push_byte;

    assign in_ready = (r_state != MARKER) && (w_count <= CNT_W'(BUF_W-8));
    assign w_accept = in_valid && in_ready;
    assign w_ack    = (r_state == MARKER) && marker_ack;

    // A stuffed FF 00 pair yields the FF; everything else pushes the raw byte.
    always_comb begin
        w_push      = 1'b0;
        w_push_byte = in_data;
        if (w_accept) begin
            if (r_state == NORMAL && in_data != BYTE_FF) begin
                w_push = 1'b1;
            end else if (r_state == GOT_FF && in_data == BYTE_STUFF) begin
                w_push      = 1'b1;
                w_push_byte = BYTE_FF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= NORMAL;
            r_marker_valid <= 1'b0;
            r_marker_code  <= 8'h00;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_accept && in_data == BYTE_FF) r_state <= GOT_FF;
                end
                GOT_FF: begin
                    if (w_accept) begin
                        if (in_data == BYTE_STUFF) begin
                            r_state <= NORMAL;
                        end else if (in_data != BYTE_FF) begin
                            r_marker_code  <= in_data;
                            r_marker_valid <= 1'b1;
                            r_state        <= MARKER;
                        end
                    end
                end
                MARKER: begin
                    if (marker_ack) begin
                        r_marker_valid <= 1'b0;
                        r_state        <= NORMAL;
                    end
                end
                default: r_state <= NORMAL;
            endcase
        end
    end

    // Marker acknowledge discards residual bits and overrides any consume.
    jpeg_bitbuf #(
        .BUF_W (BUF_W),
        .WIN_W (WIN_W),
        .CNT_W (CNT_W)
    ) u_bitbuf (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_ack),
        .push       (w_push),
        .push_byte  (w_push_byte),
        .cons_valid (cons_valid && !w_ack),
        .cons_len   (cons_len),
        .win        (win),
        .count      (w_count),
        .err        (err)
    );

    assign bits_avail   = w_count;
    assign marker_valid = r_marker_valid;
    assign marker_code  = r_marker_code;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bitstream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_bitstream_reader
// Description : Directed bench with a bit-queue reference model of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_bitstream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] win;
    logic [5:0]  bits_avail;
    logic        cons_valid = 1'b0;
    logic [4:0]  cons_len = 5'd0;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jpeg_bitstream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .win          (win),
        .bits_avail   (bits_avail),
        .cons_valid   (cons_valid),
        .cons_len     (cons_len),
        .marker_valid (marker_valid),
        .marker_code  (marker_code),
        .marker_ack   (marker_ack),
        .err          (err)
    );

    // Reference model: the buffer is a queue of stream bits, oldest first.
    bit       mq[$];
    int       m_state = 0;      // 0 data, 1 after FF, 2 holding marker
    bit       m_mv = 0;
    bit [7:0] m_code = 8'h00;
    bit       m_err = 0;
    bit       started = 0;

    function automatic bit m_ready();
        return (m_state != 2) && (mq.size() <= 24);
    endfunction

    function automatic logic [15:0] m_win();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = (i < mq.size()) ? mq[i] : 1'b1;
        return w;
    endfunction

    task automatic m_append(input bit [7:0] b);
        for (int k = 7; k >= 0; k--) mq.push_back(b[k]);
    endtask

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            mq.delete();
            m_state = 0; m_mv = 0; m_code = 8'h00; m_err = 0;
        end else begin
            bit rdy;
            rdy = m_ready();
            if (m_state == 2 && marker_ack) begin
                mq.delete();
                m_mv = 0;
                m_state = 0;
            end else if (cons_valid) begin
                if (int'(cons_len) <= mq.size()) repeat (int'(cons_len)) void'(mq.pop_front());
                else m_err = 1;
            end
            if (in_valid && rdy) begin
                if (m_state == 0) begin
                    if (in_data == 8'hFF) m_state = 1;
                    else m_append(in_data);
                end else if (m_state == 1) begin
                    if (in_data == 8'h00) begin
                        m_append(8'hFF);
                        m_state = 0;
                    end else if (in_data != 8'hFF) begin
                        m_code = in_data;
                        m_mv = 1;
                        m_state = 2;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model bits_avail", 32'(bits_avail), 32'(mq.size()));
            chk("model win", 32'(win), 32'(m_win()));
            chk("model in_ready", 32'(in_ready), 32'(m_ready()));
            chk("model marker_valid", 32'(marker_valid), 32'(m_mv));
            chk("model marker_code", 32'(marker_code), 32'(m_code));
            chk("model err", 32'(err), 32'(m_err));
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        clk1();
        in_valid = 1'b0;
    endtask

    task automatic cons(input int n);
        cons_valid = 1'b1;
        cons_len   = 5'(n);
        clk1();
        cons_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clk1(); clk1();
        rst = 1'b0;
        chk("reset bits_avail", 32'(bits_avail), 0);
        chk("reset win", 32'(win), 32'hFFFF);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset marker_valid", 32'(marker_valid), 0);
        chk("reset marker_code", 32'(marker_code), 0);
        chk("reset err", 32'(err), 0);

        // Plain bytes and a partial consume
        send(8'hA5); send(8'h3C);
        chk("plain bits_avail", 32'(bits_avail), 16);
        chk("plain win", 32'(win), 32'hA53C);
        cons(4);
        chk("consume4 win", 32'(win), 32'h53CF);
        chk("consume4 bits_avail", 32'(bits_avail), 12);
        cons(12);

        // Stuffed FF 00
        send(8'hFF); send(8'h00); send(8'h12);
        chk("stuff bits_avail", 32'(bits_avail), 16);
        chk("stuff win", 32'(win), 32'hFF12);
        cons(16);

        // Fill bytes then marker; intake held while marker pending
        send(8'h81); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hD3);
        chk("marker valid", 32'(marker_valid), 1);
        chk("marker code", 32'(marker_code), 32'hD3);
        chk("marker in_ready", 32'(in_ready), 0);
        chk("marker bits_avail", 32'(bits_avail), 8);
        chk("marker win", 32'(win), 32'h81FF);
        send(8'h55);
        chk("marker hold bits_avail", 32'(bits_avail), 8);
        marker_ack = 1'b1;
        cons(8);
        marker_ack = 1'b0;
        chk("ack bits_avail", 32'(bits_avail), 0);
        chk("ack marker_valid", 32'(marker_valid), 0);
        chk("ack in_ready", 32'(in_ready), 1);
        chk("ack err", 32'(err), 0);
        marker_ack = 1'b1;
        send(8'h77);
        marker_ack = 1'b0;
        chk("stray ack bits_avail", 32'(bits_avail), 8);
        cons(8);

        // Push and consume together, then fill to full
        send(8'h11); send(8'h22); send(8'h33);
        chk("fill24 bits_avail", 32'(bits_avail), 24);
        cons_valid = 1'b1; cons_len = 5'd8;
        send(8'h44);
        cons_valid = 1'b0;
        chk("push+cons bits_avail", 32'(bits_avail), 24);
        chk("push+cons win", 32'(win), 32'h2233);
        send(8'h55);
        chk("full bits_avail", 32'(bits_avail), 32);
        chk("full in_ready", 32'(in_ready), 0);
        send(8'h66);
        chk("full hold bits_avail", 32'(bits_avail), 32);
        cons(16);
        chk("drain win", 32'(win), 32'h4455);
        cons(16);

        // Illegal consume
        send(8'hE0);
        cons(5);
        chk("three bits win", 32'(win), 32'h1FFF);
        cons(5);
        chk("illegal err", 32'(err), 1);
        chk("illegal bits_avail", 32'(bits_avail), 3);
        cons(3);
        chk("after legal bits_avail", 32'(bits_avail), 0);
        chk("sticky err", 32'(err), 1);

        // Reset while in GOT_FF
        send(8'h12); send(8'h34); cons(4);
        send(8'hFF);
        chk("got_ff bits_avail", 32'(bits_avail), 12);
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        chk("mid reset bits_avail", 32'(bits_avail), 0);
        chk("mid reset win", 32'(win), 32'hFFFF);
        chk("mid reset err", 32'(err), 0);
        send(8'h00);
        chk("post reset bits_avail", 32'(bits_avail), 8);
        chk("post reset win", 32'(win), 32'h00FF);
        cons(0);
        chk("zero consume bits_avail", 32'(bits_avail), 8);
        chk("zero consume err", 32'(err), 0);

        clk1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jpeg_bitstream_reader.md
Name: jpeg_bitstream_reader

Overview:
- Decoder-side entropy-segment front end: accepts JPEG scan bytes, removes encoder byte stuffing (FF 00 -> FF), skips fill bytes (FF FF), detects markers, and presents an MSB-first bit window to the downstream Huffman/VLC decoder.
- Sits between the byte-stream source (DMA/FIFO) and the Huffman decoder.
- Mirrors the encoder's bit-packer/stuffer.

Parameters:
- BUF_W, 32, bit-buffer width; must be >= WIN_W + 8 + 8.
- WIN_W, 16, width of the peek window (max Huffman code + extra bits).
- CNT_W, 6, width of bit count; must satisfy 2^CNT_W > BUF_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  scan byte
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- win  out  WIN_W  next WIN_W stream bits, MSB = oldest; bits past bits_avail read as 1
- bits_avail  out  CNT_W  valid bits in buffer (0..BUF_W)
- cons_valid  in  1  consume request
- cons_len  in  5  bits to consume (0..WIN_W)
- marker_valid  out  1  marker detected, intake halted
- marker_code  out  8  second byte of marker
- marker_ack  in  1  releases marker hold
- err  out  1  sticky illegal-consume flag

Behaviour:
- Reset (synchronous, active-high; mid-operation reset has the same effect): all state cleared.
  - Outputs after reset: bits_avail=0, win=all 1s, marker_valid=0, marker_code=0, err=0, in_ready=1.
  - FSM returns to NORMAL.
- Buffer: register buf[BUF_W-1:0], MSB-aligned, plus count.
  - win = buf[BUF_W-1 -: WIN_W] with bit positions >= count forced to 1.
  - bits_avail = count.
- in_ready = (state != MARKER) && (count <= BUF_W-8). Computed from the registered count, with no combinational path from cons_*.
- FSM states:
  - NORMAL: byte != FF -> push byte. Byte == FF -> go to GOT_FF, no push.
  - GOT_FF:
    - byte 00 -> push FF, go to NORMAL.
    - byte FF -> stay in GOT_FF (fill byte discarded).
    - any other byte -> marker_code <= byte, marker_valid <= 1, go to MARKER.
  - MARKER:
    - in_ready=0. Buffered bits remain consumable, and the window pads with 1s.
    - marker_ack -> count <= 0, buf <= 0, marker_valid <= 0, go to NORMAL on the next cycle. This discards the residual partial byte.
  - marker_ack outside MARKER is ignored.
- Consume: cons_valid && cons_len <= count -> buf shifted left by cons_len, count -= cons_len.
  - cons_len > count: request ignored, err <= 1 (sticky until rst).
  - cons_len == 0 is a legal no-op.
- Simultaneous push and consume in the same cycle:
  - new count = count - cons_len + 8.
  - The byte is placed at bit positions [BUF_W-1-(count-cons_len) -: 8] of the shifted buffer.
- Simultaneous marker_ack and cons_valid: ack wins. The consume is dropped, with no error.
- Latency:
  - A pushed byte is visible in win/bits_avail on the cycle after acceptance.
  - A consume updates win on the next cycle.
  - Marker detection asserts marker_valid on the cycle after the marker byte is accepted.
- Boundary at count == BUF_W-8 with no consume: push allowed, buffer becomes full (count=BUF_W), in_ready drops.
- A trailing FF in GOT_FF is held indefinitely while waiting for the next byte; there is no timeout.

Decomposition:
- Shared package jpeg_dec_pkg:
  - FSM state enum (NORMAL, GOT_FF, MARKER).
  - Constants: BYTE_FF=8'hFF, BYTE_STUFF=8'h00, RST0..RST7 = 8'hD0..8'hD7, EOI=8'hD9.
  - Default BUF_W/WIN_W.
- One natural sub-module, jpeg_bitbuf: shift register, count, push/consume arithmetic, 1-padding. The unstuffing FSM stays in the top.

Test Plan:
- Bytes A5 3C, no consume -> bits_avail=16, win=16'hA53C; then consume 4 -> win=16'h53CF, bits_avail=12.
- Bytes FF 00 12 -> bits_avail=16, win=16'hFF12 (stuff byte removed).
- Bytes FF FF FF D3 after 8 valid bits 0x81 -> marker_valid=1, marker_code=D3, in_ready=0, bits_avail=8, win=16'h81FF; marker_ack -> bits_avail=0, marker_valid=0, in_ready=1.
- Fill to bits_avail=24 and push with consume 8 in the same cycle -> bits_avail=24, byte order preserved; fill to 32 -> in_ready=0.
- bits_avail=3, cons_len=5 -> err=1, bits_avail stays 3; another legal consume of 3 -> bits_avail=0, err still 1.
- rst asserted in GOT_FF with bits_avail=12 -> next cycle bits_avail=0, win=16'hFFFF, state NORMAL; then byte 00 is pushed as data (bits_avail=8, win=16'h00FF).
